// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction-fetch unit.
//   state_t      : fetch FSM states (IDLE -> FETCH -> EXEC -> FETCH ...)
//   *_MSB/*_LSB  : bit positions of the MIPS instruction fields in the IR
//   PC_INC       : sequential PC increment (one 32-bit word)
package ifetch_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } state_t;

  localparam int unsigned OP_MSB     = 31;
  localparam int unsigned OP_LSB     = 26;
  localparam int unsigned RS_MSB     = 25;
  localparam int unsigned RS_LSB     = 21;
  localparam int unsigned RT_MSB     = 20;
  localparam int unsigned RT_LSB     = 16;
  localparam int unsigned RD_MSB     = 15;
  localparam int unsigned RD_LSB     = 11;
  localparam int unsigned FUNC_MSB   = 5;
  localparam int unsigned FUNC_LSB   = 0;
  localparam int unsigned IMM_MSB    = 15;
  localparam int unsigned IMM_LSB    = 0;
  localparam int unsigned TARGET_MSB = 25;
  localparam int unsigned TARGET_LSB = 0;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/ifetch_unit_npc_calc.sv
// Next-PC selection (purely combinational).
//   pc       in  32 : address of the instruction in IR
//   imm      in  16 : IR immediate (branch offset in words)
//   target   in  26 : IR jump target (word index within the 256 MB region)
//   cu_jmp   in   1 : J in IR (wins over cu_br)
//   cu_br    in   1 : BEQ in IR
//   alu_zero in   1 : BEQ compare result
//   next_pc  out 32 : address of the following instruction
module npc_calc
  import ifetch_pkg::*;
(
  input  logic [31:0] pc,
  input  logic [15:0] imm,
  input  logic [25:0] target,
  input  logic        cu_jmp,
  input  logic        cu_br,
  input  logic        alu_zero,
  output logic [31:0] next_pc
);

  logic [31:0] w_pc4;
  logic [31:0] w_br_off;

  assign w_pc4    = pc + PC_INC;
  // Sign-extended word offset converted to a byte offset.
  assign w_br_off = {{14{imm[15]}}, imm, 2'b00};

  always_comb begin
    next_pc = w_pc4;
    if (cu_jmp) begin
      next_pc = {w_pc4[31:28], target, 2'b00};
    end else if (cu_br && alu_zero) begin
      next_pc = w_pc4 + w_br_off;
    end
  end

endmodule

// File: rtl/ifetch_unit.sv
// Instruction-fetch / program-counter unit of the multi-cycle MIPS-subset core.
// Owns the PC, fetches one word per instruction over a req/valid handshake and
// holds it in the IR, presenting the decoded fields to control and datapath.
//   RESET_PC          : PC after reset (bits [1:0] forced to 0)
//   clk, rst_n        : clock, asynchronous active-low reset
//   imem_req/addr     out : fetch request and word address (held until rvalid)
//   imem_rvalid/rdata in  : returned instruction word (honoured in FETCH only)
//   stall             in  : freezes the EXEC state
//   cu_jmp/cu_br      in  : J / BEQ in IR, from the control unit
//   alu_zero          in  : BEQ compare result
//   instr_valid       out : IR fields valid (EXEC)
//   pc                out : address of the instruction in IR
//   opcode..target    out : IR fields
module ifetch_unit
  import ifetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        cu_jmp,
  input  logic        cu_br,
  input  logic        alu_zero,
  output logic        instr_valid,
  output logic [31:0] pc,
  output logic [5:0]  opcode,
  output logic [4:0]  rs,
  output logic [4:0]  rt,
  output logic [4:0]  rd,
  output logic [5:0]  func,
  output logic [15:0] imm,
  output logic [25:0] target
);

  localparam logic [31:0] RESET_PC_W = {RESET_PC[31:2], 2'b00};

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic        r_req;
  logic        r_instr_valid;
  logic [31:0] w_next_pc;

  npc_calc u_npc_calc (
    .pc       (r_pc),
    .imm      (r_ir[IMM_MSB:IMM_LSB]),
    .target   (r_ir[TARGET_MSB:TARGET_LSB]),
    .cu_jmp   (cu_jmp),
    .cu_br    (cu_br),
    .alu_zero (alu_zero),
    .next_pc  (w_next_pc)
  );

  // r_req / r_instr_valid are registered copies of the state decode, so the
  // handshake outputs never depend combinationally on any input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_pc          <= RESET_PC_W;
      r_ir          <= '0;
      r_req         <= 1'b0;
      r_instr_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
          r_req   <= 1'b1;
        end
        FETCH: begin
          if (imem_rvalid) begin
            r_ir          <= imem_rdata;
            r_state       <= EXEC;
            r_req         <= 1'b0;
            r_instr_valid <= 1'b1;
          end
        end
        EXEC: begin
          if (!stall) begin
            r_pc          <= w_next_pc;
            r_state       <= FETCH;
            r_req         <= 1'b1;
            r_instr_valid <= 1'b0;
          end
        end
        default: begin
          r_state       <= IDLE;
          r_req         <= 1'b0;
          r_instr_valid <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req    = r_req;
  assign imem_addr   = r_pc;
  assign instr_valid = r_instr_valid;
  assign pc          = r_pc;
  assign opcode      = r_ir[OP_MSB:OP_LSB];
  assign rs          = r_ir[RS_MSB:RS_LSB];
  assign rt          = r_ir[RT_MSB:RT_LSB];
  assign rd          = r_ir[RD_MSB:RD_LSB];
  assign func        = r_ir[FUNC_MSB:FUNC_LSB];
  assign imm         = r_ir[IMM_MSB:IMM_LSB];
  assign target      = r_ir[TARGET_MSB:TARGET_LSB];

endmodule

// File: tb/tb_ifetch_unit.sv
module tb_ifetch_unit;

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- DUT A : RESET_PC = 0x3000 ----------------
  logic        rst_n = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata  = '0;
  logic        stall       = 1'b0;
  logic        cu_jmp      = 1'b0;
  logic        cu_br       = 1'b0;
  logic        alu_zero    = 1'b0;
  logic        instr_valid;
  logic [31:0] pc;
  logic [5:0]  opcode;
  logic [4:0]  rs, rt, rd;
  logic [5:0]  func;
  logic [15:0] imm;
  logic [25:0] target;

  ifetch_unit #(.RESET_PC(32'h0000_3000)) dut_a (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .stall(stall), .cu_jmp(cu_jmp), .cu_br(cu_br), .alu_zero(alu_zero),
    .instr_valid(instr_valid), .pc(pc), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .func(func), .imm(imm), .target(target)
  );

  // ---------------- DUT B : RESET_PC = 0xFFFF_FFFC (wrap) ----------------
  logic        b_rst_n  = 1'b0;
  logic        b_req;
  logic [31:0] b_addr;
  logic        b_rvalid = 1'b0;
  logic [31:0] b_rdata  = 32'h0022_1820;
  logic        b_stall  = 1'b0;
  logic        b_jmp    = 1'b0;
  logic        b_br     = 1'b0;
  logic        b_zero   = 1'b0;
  logic        b_valid;
  logic [31:0] b_pc;
  logic [5:0]  b_opcode;
  logic [4:0]  b_rs, b_rt, b_rd;
  logic [5:0]  b_func;
  logic [15:0] b_imm;
  logic [25:0] b_target;

  ifetch_unit #(.RESET_PC(32'hFFFF_FFFC)) dut_b (
    .clk(clk), .rst_n(b_rst_n),
    .imem_req(b_req), .imem_addr(b_addr),
    .imem_rvalid(b_rvalid), .imem_rdata(b_rdata),
    .stall(b_stall), .cu_jmp(b_jmp), .cu_br(b_br), .alu_zero(b_zero),
    .instr_valid(b_valid), .pc(b_pc), .opcode(b_opcode),
    .rs(b_rs), .rt(b_rt), .rd(b_rd), .func(b_func), .imm(b_imm), .target(b_target)
  );

  // ---------------- bookkeeping ----------------
  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
  endtask

  // ---------------- instruction memory + control-unit stand-in ----------------
  logic [31:0] w3000 = 32'h0800_0000;   // J 0x0 (later rewritten to J 0x20)
  int unsigned lat   = 0;               // extra FETCH cycles before rvalid
  logic        stray = 1'b0;            // force rvalid with junk data

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0000_3000: return w3000;
      32'h0000_0000: return 32'h0022_1820; // add  $3,$1,$2
      32'h0000_0004: return 32'h8C45_0010; // lw   $5,16($2)
      32'h0000_0008: return 32'h2108_FFFF; // addi $8,$8,-1
      32'h0000_000C: return 32'h0000_0000; // nop
      32'h0000_0010: return 32'h0800_0C00; // j    0x3000
      32'h0000_0020: return 32'h1000_FFFF; // beq  $0,$0,-1
      32'h0000_0024: return 32'h0043_2025; // or   $4,$2,$3
      default:       return 32'h0000_0000;
    endcase
  endfunction

  initial begin
    int unsigned wait_cnt;
    wait_cnt = 0;
    forever begin
      @(negedge clk);
      #2;
      cu_jmp = instr_valid && (opcode == 6'h02);
      cu_br  = instr_valid && (opcode == 6'h04);
      if (stray) begin
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hDEAD_BEEF;
      end else if (imem_req && wait_cnt >= lat) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(imem_addr);
        wait_cnt    = 0;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        if (imem_req) wait_cnt++;
        else wait_cnt = 0;
      end
    end
  end

  // ---------------- reference model (DUT A) ----------------
  // phase: 0 = waiting one cycle after reset, 1 = word requested, 2 = word held
  int          m_phase;
  logic [31:0] m_pc;
  logic [31:0] m_ir;

  function automatic logic [31:0] isa_next(input logic [31:0] cur, input logic [31:0] ir,
                                           input logic j, input logic b, input logic z);
    logic [31:0] seq;
    int          off;
    seq = cur + 32'd4;
    if (j) return (seq & 32'hF000_0000) | (32'(ir[25:0]) * 32'd4);
    if (b && z) begin
      off = int'($signed(ir[15:0]));
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_pc    <= 32'h0000_3000;
      m_ir    <= 32'h0;
    end else if (m_phase == 0) begin
      m_phase <= 1;
    end else if (m_phase == 1) begin
      if (imem_rvalid) begin
        m_ir    <= imem_rdata;
        m_phase <= 2;
      end
    end else if (!stall) begin
      m_pc    <= isa_next(m_pc, m_ir, cu_jmp, cu_br, alu_zero);
      m_phase <= 1;
    end
  end

  logic run_cmp = 1'b0;
  initial begin
    forever begin
      @(negedge clk);
      #1;
      if (run_cmp) begin
        chk("m_req",    {31'h0, imem_req},    {31'h0, m_phase == 1});
        chk("m_addr",   imem_addr,            m_pc);
        chk("m_valid",  {31'h0, instr_valid}, {31'h0, m_phase == 2});
        chk("m_pc",     pc,                   m_pc);
        chk("m_opcode", {26'h0, opcode},      {26'h0, m_ir[31:26]});
        chk("m_rs",     {27'h0, rs},          {27'h0, m_ir[25:21]});
        chk("m_rt",     {27'h0, rt},          {27'h0, m_ir[20:16]});
        chk("m_rd",     {27'h0, rd},          {27'h0, m_ir[15:11]});
        chk("m_func",   {26'h0, func},        {26'h0, m_ir[5:0]});
        chk("m_imm",    {16'h0, imm},         {16'h0, m_ir[15:0]});
        chk("m_target", {6'h0, target},       {6'h0, m_ir[25:0]});
      end
    end
  end

  // Waits (bounded) for instr_valid with pc == a; returns negedges waited.
  task automatic wait_exec(input logic [31:0] a, output int unsigned cycles);
    logic found;
    found  = 1'b0;
    cycles = 0;
    while (!found && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (instr_valid && pc == a) found = 1'b1;
    end
    chk("wait_exec_found", {31'h0, found}, 32'h1);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int unsigned cyc;
    run_cmp = 1'b1;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req",    {31'h0, imem_req}, 32'h0);
    chk("rst_pc",     pc,                32'h0000_3000);
    chk("rst_addr",   imem_addr,         32'h0000_3000);
    chk("rst_valid",  {31'h0, instr_valid}, 32'h0);
    chk("rst_fields", {opcode, rs, rt, rd, func, 5'h0}, 32'h0);
    chk("rst_imm",    {imm, 16'h0},      32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_req",  {31'h0, imem_req}, 32'h1);
    chk("rel_addr", imem_addr,         32'h0000_3000);

    // J 0 at 0x3000, then sequential 0x0, 0x4, 0x8
    wait_exec(32'h0000_3000, cyc);
    chk("j0_opcode", {26'h0, opcode}, 32'h2);
    w3000 = 32'h0800_0008;
    alu_zero = 1'b1;
    wait_exec(32'h0000_0000, cyc);
    chk("w0_rs",   {27'h0, rs},   32'd1);
    chk("w0_rt",   {27'h0, rt},   32'd2);
    chk("w0_rd",   {27'h0, rd},   32'd3);
    chk("w0_func", {26'h0, func}, 32'h20);
    wait_exec(32'h0000_0004, cyc);
    chk("zero_lat_period", cyc, 32'd2);
    chk("w4_opcode", {26'h0, opcode}, 32'h23);
    chk("w4_imm",    {16'h0, imm},    32'h0010);
    lat = 1;
    wait_exec(32'h0000_0008, cyc);
    chk("one_lat_period", cyc, 32'd3);
    chk("w8_imm", {16'h0, imm}, 32'hFFFF);

    // Jump at 0x10 -> 0x3000
    wait_exec(32'h0000_0010, cyc);
    chk("j_target", {6'h0, target}, 32'h0000_0C00);
    @(negedge clk);
    chk("jump_addr", imem_addr, 32'h0000_3000);
    chk("jump_req",  {31'h0, imem_req}, 32'h1);

    // BEQ -1 at 0x20: taken then not taken
    wait_exec(32'h0000_0020, cyc);
    chk("beq_imm", {16'h0, imm}, 32'hFFFF);
    @(negedge clk);
    chk("beq_taken_addr", imem_addr, 32'h0000_0020);
    wait_exec(32'h0000_0020, cyc);
    alu_zero = 1'b0;
    @(negedge clk);
    chk("beq_nt_addr", imem_addr, 32'h0000_0024);

    // Stall for 3 EXEC cycles with stray rvalid
    wait_exec(32'h0000_0024, cyc);
    stall = 1'b1;
    stray = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("stall_valid", {31'h0, instr_valid}, 32'h1);
      chk("stall_pc",    pc,                   32'h0000_0024);
      chk("stall_imm",   {16'h0, imm},         32'h2025);
      chk("stall_req",   {31'h0, imem_req},    32'h0);
    end
    stall = 1'b0;
    stray = 1'b0;
    lat   = 1000;

    // Reset mid-fetch with stale rvalid landing in IDLE
    @(negedge clk);
    chk("pend_req",  {31'h0, imem_req}, 32'h1);
    chk("pend_addr", imem_addr,         32'h0000_0028);
    rst_n = 1'b0;
    stray = 1'b1;
    @(negedge clk);
    chk("mid_rst_req", {31'h0, imem_req}, 32'h0);
    chk("mid_rst_pc",  pc,                32'h0000_3000);
    rst_n = 1'b1;
    @(negedge clk);
    stray = 1'b0;
    chk("stale_req",   {31'h0, imem_req},    32'h1);
    chk("stale_valid", {31'h0, instr_valid}, 32'h0);
    chk("stale_ir",    {opcode, 10'h0, imm}, 32'h0);
    lat = 0;
    wait_exec(32'h0000_3000, cyc);
    chk("refetch_target", {6'h0, target}, 32'h0000_0008);
    run_cmp = 1'b0;

    // Wrap-around on DUT B
    @(negedge clk);
    b_rst_n = 1'b1;
    @(negedge clk);
    chk("wrap_req0",  {31'h0, b_req}, 32'h1);
    chk("wrap_addr0", b_addr,         32'hFFFF_FFFC);
    b_rvalid = 1'b1;
    @(negedge clk);
    b_rvalid = 1'b0;
    chk("wrap_valid", {31'h0, b_valid}, 32'h1);
    chk("wrap_rd",    {27'h0, b_rd},    32'd3);
    @(negedge clk);
    chk("wrap_req1",  {31'h0, b_req}, 32'h1);
    chk("wrap_addr1", b_addr,         32'h0000_0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
